// File: rtl/cam_dvp_capture_if.sv
// Camera DVP input bus and packed-pixel output bus shared by the capture block and its environment.
interface cam_dvp_capture_if #(
  parameter int ADDR_BITS = 20
);
  logic                 cam_vsync;
  logic                 cam_href;
  logic [7:0]           cam_data;
  logic                 pix_valid;
  logic [23:0]          pix_rgb;
  logic [ADDR_BITS-1:0] pix_addr;

  modport slave (
    input  cam_vsync, cam_href, cam_data,
    output pix_valid, pix_rgb, pix_addr
  );

  modport master (
    output cam_vsync, cam_href, cam_data,
    input  pix_valid, pix_rgb, pix_addr
  );
endinterface

// File: rtl/cam_dvp_capture.sv
// DVP RGB565 camera capture: packs byte pairs into RGB888 pixels with linear frame-buffer addresses.
// Optional statistics outputs (frame_count, last_line_pixels) are enabled by `define CAM_CAPTURE_STATS_EN.
module cam_dvp_capture #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int ADDR_BITS = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  cam_dvp_capture_if.slave    cam,
  output logic                frame_start,
  output logic                done,
  output logic                busy,
  output logic                err
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [15:0]         frame_count,
  output logic [11:0]         last_line_pixels
`endif
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SYNC, S_ACTIVE} state_t;

  state_t               state;
  logic                 vsync_d;
  logic                 href_d;
  logic                 phase;
  logic [7:0]           hi_byte;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [ADDR_BITS-1:0] addr;
  logic [ADDR_BITS-1:0] line_base;

  logic        vsync_rise, vsync_fall, href_fall;
  logic        in_range, last_line;
  logic [4:0]  r5, b5;
  logic [5:0]  g6;
  logic [23:0] rgb888;

  assign vsync_rise = cam.cam_vsync & ~vsync_d;
  assign vsync_fall = ~cam.cam_vsync & vsync_d;
  assign href_fall  = ~cam.cam_href & href_d;
  assign in_range   = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
  assign last_line  = (y == YW'(V_ACTIVE - 1));

  // RGB565 split across the two bytes; expansion replicates the top bits into the low bits.
  assign r5     = hi_byte[7:3];
  assign g6     = {hi_byte[2:0], cam.cam_data[7:5]};
  assign b5     = cam.cam_data[4:0];
  assign rgb888 = {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};

  // Edge detectors reset to the blanking levels so leaving reset during blanking creates no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      vsync_d       <= 1'b1;
      href_d        <= 1'b0;
      phase         <= 1'b0;
      hi_byte       <= '0;
      x             <= '0;
      y             <= '0;
      addr          <= '0;
      line_base     <= '0;
      cam.pix_valid <= 1'b0;
      cam.pix_rgb   <= '0;
      cam.pix_addr  <= '0;
      frame_start   <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      err           <= 1'b0;
`ifdef CAM_CAPTURE_STATS_EN
      frame_count      <= '0;
      last_line_pixels <= '0;
`endif
    end else begin
      vsync_d       <= cam.cam_vsync;
      href_d        <= cam.cam_href;
      cam.pix_valid <= 1'b0;
      frame_start   <= 1'b0;
      done          <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ARMED;
            busy  <= 1'b1;
            err   <= 1'b0;
          end
        end
        S_ARMED: begin
          if (cam.cam_vsync) state <= S_SYNC;
        end
        S_SYNC: begin
          if (vsync_fall) begin
            state       <= S_ACTIVE;
            frame_start <= 1'b1;
            x           <= '0;
            y           <= '0;
            addr        <= '0;
            line_base   <= '0;
            phase       <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (vsync_rise) begin
            done  <= 1'b1;
            err   <= 1'b1;
            phase <= 1'b0;
            state <= continuous ? S_SYNC : S_IDLE;
            busy  <= continuous;
          end else if (href_fall) begin
            // Short lines jump straight to the next line base; a dangling byte is an error.
            phase     <= 1'b0;
            x         <= '0;
            y         <= y + 1'b1;
            line_base <= line_base + ADDR_BITS'(H_ACTIVE);
            addr      <= line_base + ADDR_BITS'(H_ACTIVE);
            if (phase) err <= 1'b1;
`ifdef CAM_CAPTURE_STATS_EN
            last_line_pixels <= 12'(x);
`endif
            if (last_line) begin
              done  <= 1'b1;
              state <= continuous ? S_SYNC : S_IDLE;
              busy  <= continuous;
`ifdef CAM_CAPTURE_STATS_EN
              if (!err && !phase) frame_count <= frame_count + 16'd1;
`endif
            end
          end else if (cam.cam_href) begin
            if (!phase) begin
              hi_byte <= cam.cam_data;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (in_range) begin
                cam.pix_valid <= 1'b1;
                cam.pix_rgb   <= rgb888;
                cam.pix_addr  <= addr;
                addr          <= addr + 1'b1;
                x             <= x + 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cam_dvp_capture.md
CAM_DVP_CAPTURE -- requirements
Module: cam_dvp_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 SHALL have parameter ADDR_BITS, default 20, frame-buffer word address width.
REQ-004 SHALL have port clk, input, 1, camera pixel clock; sole clock, all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse arming capture.
REQ-007 SHALL have port continuous, input, 1, 1 = re-arm automatically after each frame.
REQ-008 SHALL have port cam_vsync, input, 1, camera vertical sync, high during blanking.
REQ-009 SHALL have port cam_href, input, 1, camera line valid, high during active bytes.
REQ-010 SHALL have port cam_data, input, 8, camera byte bus.
REQ-011 SHALL have port pix_valid, output, 1, one-cycle strobe with each packed pixel.
REQ-012 SHALL have port pix_rgb, output, 24, {R8,G8,B8} pixel.
REQ-013 SHALL have port pix_addr, output, ADDR_BITS, linear address y*H_ACTIVE+x of pix_rgb.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse on first capture cycle of a frame.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when a frame completes or aborts.
REQ-016 SHALL have port busy, output, 1, high from arm until done.
REQ-017 SHALL have port err, output, 1, sticky error flag; cleared by start.

Function
REQ-018 SHALL implement states S_IDLE, S_ARMED, S_SYNC, S_ACTIVE.
REQ-019 S_IDLE: start -> S_ARMED, busy=1, err cleared; start in other states ignored.
REQ-020 S_ARMED: wait cam_vsync=1 -> S_SYNC; never begin mid-frame.
REQ-021 S_SYNC: cam_vsync falling edge -> S_ACTIVE, frame_start pulse same cycle, x=0, y=0, address=0, byte phase=0.
REQ-022 S_ACTIVE, cam_href=1: phase 0 latches cam_data as high byte {R5,G6[5:3]}; phase 1 forms {G6[2:0],B5}.
REQ-023 pix_valid, pix_rgb, pix_addr SHALL be registered, asserting the cycle after the phase-1 byte (latency 1).
REQ-024 Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-025 Address SHALL be an incrementing counter (no multiplier); x increments per pixel; href falling edge -> x=0, y+1, phase=0.
REQ-026 Odd byte count at href fall: partial byte discarded, err=1.
REQ-027 x>=H_ACTIVE or y>=V_ACTIVE: pixel dropped (no pix_valid), err=1, address frozen.
REQ-028 Frame complete: y reaches V_ACTIVE at href fall -> done pulse; continuous=1 -> S_SYNC else S_IDLE, busy=0.
REQ-029 cam_vsync rising in S_ACTIVE before V_ACTIVE lines: abort, done pulse, err=1, same next-state rule as REQ-028.
REQ-030 Line with fewer than H_ACTIVE pixels SHALL NOT set err; address jumps to next line base (y+1)*H_ACTIVE.
REQ-031 continuous deasserted mid-frame: current frame completes, then S_IDLE.

Reset
REQ-032 reset=0 SHALL asynchronously force S_IDLE; pix_valid, frame_start, done, busy, err=0; pix_rgb, pix_addr=0; x, y, phase=0.
REQ-033 Reset mid-frame SHALL discard partial pixel; after release capture resumes only via start and next vsync cycle.
REQ-034 Edge-detect registers for cam_vsync/cam_href SHALL reset to 1/0 so release during blanking yields no false edge.

Configuration
REQ-035 Macro CAM_CAPTURE_STATS_EN defined: add outputs frame_count[15:0] (increments on each done without err, wraps 0xFFFF->0) and last_line_pixels[11:0] (x at last href fall).
REQ-036 Macro undefined: those ports and counters absent; all other behaviour identical.

Verification
REQ-037 Reset, start, one frame H_ACTIVE=4 V_ACTIVE=2, bytes 0xF8,0x00 per pixel -> 8 pix_valid, pix_rgb=0xFF0000, addr 0..7, one done, err=0.
REQ-038 Bytes 0x07,0xE0 -> pix_rgb=0x00FF00; bytes 0x00,0x1F -> 0x0000FF; pix_valid one cycle after second byte.
REQ-039 Line with 3 bytes -> 1 pixel emitted, err=1; next line addr=4 (H_ACTIVE=4).
REQ-040 vsync rises after 1 of 2 lines -> done pulse, err=1, busy=0 with continuous=0.
REQ-041 continuous=1, 3 frames -> 3 frame_start, 3 done, busy held high; with STATS_EN frame_count=3.
REQ-042 Assert reset mid-line -> all outputs 0 immediately (before next clk edge); no pixel until start plus new vsync.
